// File: rtl/issue_if.sv
// D-stage pair and issue-decision signals between decode and the issue scoreboard.
interface issue_if;
  logic       validD1, validD2;
  logic [4:0] rs1D1, rs2D1, rs1D2, rs2D2;
  logic       use_rs2D1, use_rs2D2;
  logic [4:0] rdD1, rdD2;
  logic       reg_writeD1, reg_writeD2;
  logic       is_loadD1, is_loadD2;
  logic       freeze, flush;
  logic       issue1, issue2, stall, split;

  modport master (
    output validD1, validD2, rs1D1, rs2D1, rs1D2, rs2D2, use_rs2D1, use_rs2D2,
           rdD1, rdD2, reg_writeD1, reg_writeD2, is_loadD1, is_loadD2, freeze, flush,
    input  issue1, issue2, stall, split
  );
  modport slave (
    input  validD1, validD2, rs1D1, rs2D1, rs1D2, rs2D2, use_rs2D1, use_rs2D2,
           rdD1, rdD2, reg_writeD1, reg_writeD2, is_loadD1, is_loadD2, freeze, flush,
    output issue1, issue2, stall, split
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Dual-issue D-stage scheduler: per-register load-pending counters plus a PAIR/SPLIT FSM
// that splits dependent pairs and holds D until load results are forwardable.
module issue_scoreboard #(
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 2
) (
  input  logic clk,
  input  logic rst,
  issue_if.slave bus
);
  typedef enum logic {PAIR, SPLIT} state_e;

  state_e                   state_q, state_d;
  logic [31:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]              pend;
  logic                     haz1, haz2, dep;
  logic                     issue1, issue2, stall, split;
  logic                     set1, set2;

  // cnt_q[0] is never written nonzero, so x0 is never pending
  always_comb begin
    for (int r = 0; r < 32; r++) pend[r] = (cnt_q[r] != '0);
  end

  always_comb begin
    haz1 = bus.validD1 & (pend[bus.rs1D1] | (bus.use_rs2D1 & pend[bus.rs2D1]));
    haz2 = bus.validD2 & (pend[bus.rs1D2] | (bus.use_rs2D2 & pend[bus.rs2D2]));
    dep  = bus.reg_writeD1 & (bus.rdD1 != 5'd0) &
           ((bus.rs1D2 == bus.rdD1) | (bus.use_rs2D2 & (bus.rs2D2 == bus.rdD1)) |
            (bus.reg_writeD2 & (bus.rdD2 == bus.rdD1)));
  end

  always_comb begin
    issue1  = 1'b0;
    issue2  = 1'b0;
    stall   = 1'b0;
    split   = 1'b0;
    state_d = state_q;
    if (rst) begin
      state_d = PAIR;
    end else if (bus.flush) begin
      split   = (state_q == SPLIT);
      state_d = PAIR;
    end else if (bus.freeze) begin
      split = (state_q == SPLIT);
      stall = 1'b1;
    end else begin
      split = (state_q == SPLIT);
      if (state_q == PAIR) begin
        issue1 = bus.validD1 & ~haz1;
        issue2 = issue1 & bus.validD2 & ~haz2 & ~dep;
        stall  = (bus.validD1 & ~issue1) | (bus.validD2 & ~issue2);
        if (issue1 & bus.validD2 & ~issue2) state_d = SPLIT;
      end else begin
        issue2 = bus.validD2 & ~haz2;
        stall  = ~issue2;
        if (issue2) state_d = PAIR;
      end
    end
  end

  // Counters keep running through flush: older loads still complete
  always_comb begin
    cnt_d = cnt_q;
    if (!rst && !bus.freeze) begin
      for (int r = 1; r < 32; r++) begin
        set1 = issue1 & bus.is_loadD1 & (bus.rdD1 == 5'(r));
        set2 = issue2 & bus.is_loadD2 & (bus.rdD2 == 5'(r));
        if (set1 | set2)           cnt_d[r] = CNT_W'(LOAD_LAT);
        else if (cnt_q[r] != '0)   cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
    cnt_d[0] = '0;
    set1 = 1'b0;
    set2 = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PAIR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.issue1 = issue1;
  assign bus.issue2 = issue2;
  assign bus.stall  = stall;
  assign bus.split  = split;
endmodule
